abacus_counter_bank: RTL

- Parametrised, Wishbone-mapped bank of NUM_COUNTERS event counters for the ABACUS profiler; the next-generation replacement for fixed per-category counter registers.
- Each channel counts single-cycle event pulses from a profiling unit (instruction mix, cache, branch, and similar).
- Adds per-channel enable, a global enable, wrap or saturate mode, atomic snapshot, clear-all, sticky overflow status and an overflow interrupt.

---
 rtl/abacus_counter_bank.sv | 133 +++++++++++++
 1 files changed

// File: rtl/abacus_counter_bank.sv
// ABACUS profiler event-counter bank: NUM_COUNTERS counters behind a Wishbone register
// window, with wrap/saturate, atomic snapshot, clear-all, sticky overflow and interrupt.
module abacus_counter_bank #(
   parameter logic [31:0] BASE_ADDR     = 32'hf0030000,
   parameter int          NUM_COUNTERS  = 10,
   parameter int          COUNTER_WIDTH = 48
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [NUM_COUNTERS-1:0] event_inc,
   input  logic                    wb_cyc,
   input  logic                    wb_stb,
   input  logic                    wb_we,
   input  logic [31:0]             wb_adr,
   input  logic [31:0]             wb_dat_i,
   output logic [31:0]             wb_dat_o,
   output logic                    wb_ack,
   output logic                    irq
);

   localparam int NC = NUM_COUNTERS;
   localparam int CW = COUNTER_WIDTH;

   logic          global_en, saturate, read_snap, irq_en;
   logic [NC-1:0] ch_en, ovf, ovf_set, ovf_nxt;
   logic [CW-1:0] cnt [NC];
   logic [CW-1:0] snap [NC];
   logic [CW-1:0] cnt_nxt [NC];

   logic          access, hit, wr;
   logic          wr_ctrl, wr_chen, wr_cmd, wr_ovf;
   logic          clear_all, snapshot;
   logic [9:0]    word;
   logic [4:0]    ch_sel;
   logic [CW-1:0] sel_val;
   logic [63:0]   sel_ext;
   logic [31:0]   rdata;

   // Increment with wrap or saturate; MSB of the result flags the all-ones rollover.
   function automatic logic [CW:0] bump(input logic [CW-1:0] v, input logic sat);
      if (&v)
         bump = {1'b1, (sat ? v : {CW{1'b0}})};
      else
         bump = {1'b0, v + CW'(1)};
   endfunction

   assign access    = wb_cyc & wb_stb & ~wb_ack;
   assign hit       = (wb_adr[31:12] == BASE_ADDR[31:12]);
   assign word      = wb_adr[11:2];
   assign ch_sel    = wb_adr[7:3];
   assign wr        = access & wb_we & hit;
   assign wr_ctrl   = wr && (word == 10'h000);
   assign wr_chen   = wr && (word == 10'h001);
   assign wr_cmd    = wr && (word == 10'h002);
   assign wr_ovf    = wr && (word == 10'h003);
   assign clear_all = wr_cmd & wb_dat_i[0];
   assign snapshot  = wr_cmd & wb_dat_i[1];

   always_comb begin
      sel_val = '0;
      for (int i = 0; i < NC; i++) begin
         if (ch_sel == 5'(i))
            sel_val = read_snap ? snap[i] : cnt[i];
      end
      sel_ext = 64'(sel_val);
   end

   // Channels at or beyond NC never match ch_sel above, so they read back 0.
   always_comb begin
      rdata = '0;
      if (hit) begin
         case (word)
            10'h000: rdata = {28'b0, irq_en, read_snap, saturate, global_en};
            10'h001: rdata = 32'(ch_en);
            10'h003: rdata = 32'(ovf);
            default: begin
               if (wb_adr[11:8] == 4'h1)
                  rdata = wb_adr[2] ? sel_ext[63:32] : sel_ext[31:0];
            end
         endcase
      end
   end

   always_comb begin
      for (int i = 0; i < NC; i++) begin
         cnt_nxt[i] = cnt[i];
         ovf_set[i] = 1'b0;
         if (event_inc[i] & ch_en[i] & global_en)
            {ovf_set[i], cnt_nxt[i]} = bump(cnt[i], saturate);
         if (clear_all) begin
            cnt_nxt[i] = '0;
            ovf_set[i] = 1'b0;
         end
      end
      if (clear_all)
         ovf_nxt = '0;
      else
         ovf_nxt = (ovf & ~(wr_ovf ? wb_dat_i[NC-1:0] : {NC{1'b0}})) | ovf_set;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wb_ack    <= 1'b0;
         wb_dat_o  <= '0;
         irq       <= 1'b0;
         global_en <= 1'b0;
         saturate  <= 1'b0;
         read_snap <= 1'b0;
         irq_en    <= 1'b0;
         ch_en     <= '0;
         ovf       <= '0;
         for (int i = 0; i < NC; i++) begin
            cnt[i]  <= '0;
            snap[i] <= '0;
         end
      end else begin
         wb_ack   <= access;
         wb_dat_o <= (access && !wb_we) ? rdata : 32'h0;
         irq      <= irq_en & (|ovf);
         if (wr_ctrl)
            {irq_en, read_snap, saturate, global_en} <= wb_dat_i[3:0];
         if (wr_chen)
            ch_en <= wb_dat_i[NC-1:0];
         ovf <= ovf_nxt;
         for (int i = 0; i < NC; i++) begin
            cnt[i] <= cnt_nxt[i];
            if (snapshot)
               snap[i] <= cnt[i];
         end
      end
   end

endmodule
